// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO input capture block: default geometry,
// register address spaces and the post-reset arming delay.
package gpio_pkg;

  localparam int GPIO_N     = 4;
  localparam int GPIO_WIDTH = 32;
  localparam int GPIO_AW    = 2;

  // addr MSB selects the register space
  localparam logic ADDR_SNAP = 1'b0;
  localparam logic ADDR_PEND = 1'b1;

  localparam logic [1:0] ARM_CYCLES = 2'd3;

  typedef enum logic {
    SPACE_SNAP = 1'b0,
    SPACE_PEND = 1'b1
  } space_e;

  function automatic space_e space_of(input logic msb);
    return (msb == ADDR_PEND) ? SPACE_PEND : SPACE_SNAP;
  endfunction

endpackage

// File: rtl/gpio_in_capture_if.sv
// Register access bus shared with the GPIO output bank: select, read/write
// strobes, address and write data in; registered read data and valid out.
interface gpio_in_capture_if #(
  parameter int WIDTH = gpio_pkg::GPIO_WIDTH,
  parameter int AW    = gpio_pkg::GPIO_AW
);

  logic             sel;
  logic             ren;
  logic             wen;
  logic [AW:0]      addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;

  modport master (
    output sel, ren, wen, addr, wdata,
    input  rdata, rvalid
  );

  modport slave (
    input  sel, ren, wen, addr, wdata,
    output rdata, rvalid
  );

endinterface

// File: rtl/gpio_sync_edge.sv
// One bank of pin conditioning: 2-flop synchronizer, previous-value register
// and rise/fall event generation gated by the arm qualifier.
module gpio_sync_edge
  import gpio_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] i_pins,
  input  logic             i_armed,
  input  logic             i_edge_any,
  output logic [WIDTH-1:0] o_sync2,
  output logic [WIDTH-1:0] o_ev
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= i_pins;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise  = r_sync2 & ~r_prev;
  assign w_fall  = ~r_sync2 & r_prev;
  assign o_sync2 = r_sync2;

  // before arming, the synchronizer is still filling from reset zeros
  assign o_ev = !i_armed   ? '0 :
                i_edge_any ? (w_rise | w_fall) : w_rise;

endmodule

// File: rtl/gpio_in_capture.sv
// GPIO input capture: per-bank synchronized snapshots refreshed round-robin,
// sticky W1C edge-pending registers, register read-back and aggregate irq.
module gpio_in_capture
  import gpio_pkg::*;
#(
  parameter int N     = GPIO_N,
  parameter int WIDTH = GPIO_WIDTH,
  parameter int AW    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N*WIDTH-1:0]   gpio_pins,
  input  logic                 edge_any,
  gpio_in_capture_if.slave     bus,
  output logic                 irq
);

  localparam logic [AW-1:0] SCAN_STEP = AW'(1);

  logic [AW-1:0]    r_scan;
  logic [1:0]       r_arm;
  logic [WIDTH-1:0] r_snap [N];
  logic [WIDTH-1:0] r_pend [N];
  logic [WIDTH-1:0] r_rdata;
  logic             r_rvalid;
  logic             r_irq;

  logic             w_armed;
  logic             w_wr;
  logic             w_rd;
  logic [AW-1:0]    w_idx;
  logic [WIDTH-1:0] w_sync2 [N];
  logic [WIDTH-1:0] w_ev    [N];
  logic [WIDTH-1:0] w_clr   [N];
  logic             w_any_pend;

  assign w_armed = (r_arm == ARM_CYCLES);
  assign w_wr    = bus.sel & bus.wen;
  assign w_rd    = bus.sel & bus.ren;
  assign w_idx   = bus.addr[AW-1:0];

  for (genvar g = 0; g < N; g++) begin : g_bank
    gpio_sync_edge #(
      .WIDTH (WIDTH)
    ) u_sync_edge (
      .clk        (clk),
      .rstn       (rstn),
      .i_pins     (gpio_pins[g*WIDTH +: WIDTH]),
      .i_armed    (w_armed),
      .i_edge_any (edge_any),
      .o_sync2    (w_sync2[g]),
      .o_ev       (w_ev[g])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_scan <= '0;
      r_arm  <= '0;
    end else begin
      r_scan <= r_scan + SCAN_STEP;
      if (r_arm != ARM_CYCLES) begin
        r_arm <= r_arm + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < N; k++) begin
        r_snap[k] <= '0;
      end
    end else begin
      r_snap[r_scan] <= w_sync2[r_scan];
    end
  end

  // snapshot-space writes never match here, so they fall through harmlessly
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_clr[k] = '0;
      if (w_wr && (bus.addr == {ADDR_PEND, k[AW-1:0]})) begin
        w_clr[k] = bus.wdata;
      end
    end
  end

  // a new event on a bit being cleared in the same cycle survives the clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < N; k++) begin
        r_pend[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        r_pend[k] <= (r_pend[k] & ~w_clr[k]) | w_ev[k];
      end
    end
  end

  always_comb begin
    w_any_pend = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_any_pend = w_any_pend | (|r_pend[k]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_any_pend;
    end
  end

  // reads sample pre-edge state, so a same-cycle W1C returns the old value
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) begin
        if (space_of(bus.addr[AW]) == SPACE_PEND) begin
          r_rdata <= r_pend[w_idx];
        end else begin
          r_rdata <= r_snap[w_idx];
        end
      end
    end
  end

  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
  assign irq        = r_irq;

endmodule

// File: tb/tb_gpio_in_capture.sv
// Scoreboard bench for gpio_in_capture: reads push the reference model's
// expected value, a negedge monitor pops and compares on every rvalid.
module tb_gpio_in_capture;

  localparam int N     = 4;
  localparam int WIDTH = 32;
  localparam int AW    = 2;

  logic               clk = 1'b0;
  logic               rstn;
  logic [N*WIDTH-1:0] gpio_pins;
  logic               edge_any;
  logic               irq;

  gpio_in_capture_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  gpio_in_capture #(.N(N), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .gpio_pins (gpio_pins),
    .edge_any  (edge_any),
    .bus       (bus.slave),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q  [$];
  string            name_q [$];

  // reference model: pin levels as driven and accumulated pending events
  logic [WIDTH-1:0] m_pins [N];
  logic [WIDTH-1:0] m_pend [N];
  logic             m_edge_any;

  always @(negedge clk) begin
    logic [WIDTH-1:0] e;
    string            nm;
    if (rstn === 1'b1 && bus.rvalid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got %h with no expected read", bus.rdata);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (bus.rdata !== e) begin
          errors++;
          $display("FAIL %s got %h expected %h", nm, bus.rdata, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (N + 4) tick();
  endtask

  task automatic chk(input string nm, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic model_irq();
    logic a = 1'b0;
    for (int k = 0; k < N; k++) a = a | (|m_pend[k]);
    return a;
  endfunction

  task automatic drive_pins();
    for (int k = 0; k < N; k++) gpio_pins[k*WIDTH +: WIDTH] = m_pins[k];
  endtask

  task automatic set_bank(input int k, input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] ev;
    ev = m_edge_any ? (m_pins[k] ^ v) : (v & ~m_pins[k]);
    m_pend[k] = m_pend[k] | ev;
    m_pins[k] = v;
    drive_pins();
  endtask

  task automatic set_edge_any(input logic v);
    edge_any   = v;
    m_edge_any = v;
    tick();
    tick();
  endtask

  task automatic rd(input logic pend, input int k, input string nm);
    bus.sel  = 1'b1;
    bus.ren  = 1'b1;
    bus.addr = {pend, k[AW-1:0]};
    exp_q.push_back(pend ? m_pend[k] : m_pins[k]);
    name_q.push_back(nm);
    tick();
    bus.sel = 1'b0;
    bus.ren = 1'b0;
  endtask

  task automatic wr_raw(input logic [AW:0] a, input logic [WIDTH-1:0] w);
    bus.sel   = 1'b1;
    bus.wen   = 1'b1;
    bus.addr  = a;
    bus.wdata = w;
    tick();
    bus.sel = 1'b0;
    bus.wen = 1'b0;
  endtask

  task automatic wr_pend(input int k, input logic [WIDTH-1:0] w);
    logic [AW:0] a;
    a = {1'b1, k[AW-1:0]};
    wr_raw(a, w);
    m_pend[k] = m_pend[k] & ~w;
  endtask

  task automatic clear_all();
    for (int k = 0; k < N; k++) wr_pend(k, '1);
  endtask

  initial begin
    logic [AW:0] a;
    bus.sel = 1'b0; bus.ren = 1'b0; bus.wen = 1'b0;
    bus.addr = '0; bus.wdata = '0;
    edge_any = 1'b0; m_edge_any = 1'b0;
    rstn = 1'b0;
    for (int k = 0; k < N; k++) begin
      m_pins[k] = '1;
      m_pend[k] = '0;
    end
    drive_pins();

    // reset with pins high from time 0: no pending, snapshots all ones
    repeat (2) tick();
    chk("rst_rdata", bus.rdata, '0);
    chk("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rstn = 1'b1;
    settle();
    chk("arm_irq", {31'd0, irq}, 32'd0);
    for (int k = 0; k < N; k++) rd(1'b0, k, "rst_snap");
    for (int k = 0; k < N; k++) rd(1'b1, k, "rst_pend");
    chk("rvalid_hi", {31'd0, bus.rvalid}, 32'd1);
    tick();
    chk("rvalid_drop", {31'd0, bus.rvalid}, 32'd0);

    // rising edge latency on bank 2 bit 0
    for (int k = 0; k < N; k++) set_bank(k, '0);
    settle();
    chk("quiet_irq", {31'd0, irq}, {31'd0, model_irq()});
    set_bank(2, 32'h1);
    tick(); tick(); tick();
    chk("lat_irq_e2", {31'd0, irq}, 32'd0);
    tick();
    chk("lat_irq_e3", {31'd0, irq}, 32'd1);
    rd(1'b1, 2, "b2_pend");
    set_bank(2, 32'h0);
    settle();
    rd(1'b1, 2, "b2_fall_ignored");
    wr_pend(2, '1);
    tick();
    chk("b2_clr_irq", {31'd0, irq}, 32'd0);

    // both-edge detection and partial W1C on bank 1
    set_edge_any(1'b1);
    set_bank(1, 32'h0000_00F0);
    settle();
    set_bank(1, 32'h0000_000F);
    settle();
    rd(1'b1, 1, "b1_both");
    chk("b1_model", m_pend[1], 32'h0000_00FF);
    wr_pend(1, 32'h0F);
    tick();
    chk("b1_part_irq", {31'd0, irq}, 32'd1);
    rd(1'b1, 1, "b1_part");
    wr_pend(1, 32'hF0);
    chk("b1_irq_lag", {31'd0, irq}, 32'd1);
    tick();
    chk("b1_irq_drop", {31'd0, irq}, 32'd0);

    // set and clear colliding on bank 3 bit 5
    set_bank(3, 32'h20);
    settle();
    set_bank(3, 32'h0);
    tick(); tick();
    wr_pend(3, 32'h20);
    m_pend[3] = m_pend[3] | 32'h20;
    rd(1'b1, 3, "b3_set_wins");
    bus.sel = 1'b1; bus.ren = 1'b1; bus.wen = 1'b1;
    bus.addr = {1'b1, 2'd3}; bus.wdata = 32'h20;
    exp_q.push_back(m_pend[3]);
    name_q.push_back("b3_rdwr_preclr");
    tick();
    bus.sel = 1'b0; bus.ren = 1'b0; bus.wen = 1'b0;
    m_pend[3] = m_pend[3] & ~32'h20;
    rd(1'b1, 3, "b3_after_clr");

    // writes to snapshot space are ignored
    set_bank(0, $urandom);
    settle();
    a = {1'b0, 2'd0};
    wr_raw(a, 32'hDEAD_BEEF);
    settle();
    rd(1'b0, 0, "snap_wr_ignored");

    // randomized traffic against the model
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 3) == 0) set_edge_any(~m_edge_any);
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 1) == 1) set_bank(k, $urandom);
      settle();
      chk("rnd_irq", {31'd0, irq}, {31'd0, model_irq()});
      for (int r = 0; r < 3; r++)
        rd(1'($urandom_range(0, 1)), int'($urandom_range(0, N-1)), "rnd_rd");
      wr_pend(int'($urandom_range(0, N-1)), $urandom);
      tick();
      chk("rnd_w1c_irq", {31'd0, irq}, {31'd0, model_irq()});
    end

    // asynchronous reset during a read with pending bits set
    set_edge_any(1'b0);
    for (int k = 0; k < N; k++) set_bank(k, '0);
    settle();
    clear_all();
    set_bank(0, 32'h0000_FFFF);
    settle();
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    bus.sel = 1'b1; bus.ren = 1'b1; bus.addr = {1'b1, 2'd0};
    @(posedge clk);
    #1;
    bus.sel = 1'b0; bus.ren = 1'b0;
    chk("pre_rst_rvalid", {31'd0, bus.rvalid}, 32'd1);
    chk("pre_rst_rdata", bus.rdata, 32'h0000_FFFF);
    #1 rstn = 1'b0;
    #1;
    chk("async_rdata", bus.rdata, '0);
    chk("async_rvalid", {31'd0, bus.rvalid}, 32'd0);
    chk("async_irq", {31'd0, irq}, 32'd0);
    tick();
    rstn = 1'b1;
    for (int k = 0; k < N; k++) m_pend[k] = '0;
    settle();
    chk("post_rst_irq", {31'd0, irq}, 32'd0);
    rd(1'b1, 0, "post_rst_pend");
    rd(1'b0, 0, "post_rst_snap");
    tick(); tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rd_missing got %0d outstanding expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
